// File: rtl/io_input_cond.sv
// Board switch/key conditioning: 2-FF sync, key polarity normalisation, per-bit
// counter debounce, and sticky key-press flags cleared by the core.
module io_input_cond #(
  parameter int N_SW            = 18,
  parameter int N_KEY           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SW-1:0]  sw_raw_i,
  input  logic [N_KEY-1:0] key_raw_i,
  input  logic [N_KEY-1:0] key_ack_i,
  output logic [31:0]      io_sw_o,
  output logic [31:0]      io_key_o,
  output logic             key_irq_o
);

  localparam int NB = N_SW + N_KEY;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Keys sit in the upper bits; their sync FFs reset to the released pin level.
  localparam logic [NB-1:0] KEY_POL = {{N_KEY{KEY_ACTIVE_LOW}}, {N_SW{1'b0}}};

  logic [NB-1:0]    s1_q, s2_q, db_q, db_d, lvl;
  logic [CW-1:0]    cnt_q [NB];
  logic [CW-1:0]    cnt_d [NB];
  logic [N_KEY-1:0] flag_q, flag_d, rise;
  logic             irq_q;

  assign lvl = s2_q ^ KEY_POL;

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (lvl[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]  = lvl[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    rise   = db_d[NB-1:N_SW] & ~db_q[NB-1:N_SW];
    // A new press outranks a same-cycle ack so no press is lost.
    flag_d = rise | (flag_q & ~key_ack_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= KEY_POL;
      s2_q   <= KEY_POL;
      db_q   <= '0;
      flag_q <= '0;
      irq_q  <= 1'b0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      s1_q   <= {key_raw_i, sw_raw_i};
      s2_q   <= s1_q;
      db_q   <= db_d;
      flag_q <= flag_d;
      irq_q  <= |flag_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    io_sw_o             = '0;
    io_sw_o[N_SW-1:0]   = db_q[N_SW-1:0];
    io_key_o            = '0;
    io_key_o[16+:N_KEY] = flag_q;
    io_key_o[0+:N_KEY]  = db_q[NB-1:N_SW];
  end

  assign key_irq_o = irq_q;

endmodule
